// File: rtl/alu_issue_stage.sv
// Execute-issue stage: operand forwarding/selection and a registered valid/ready hand-off to the ALU.
// Build option ALU_ISSUE_SKID_EN adds a skid entry so d_ready can come straight from a flop.
module alu_issue_stage (
    input  logic        clock,
    input  logic        resetn,
    input  logic        flush,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [3:0]  d_aluc,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [31:0] d_rs_val,
    input  logic [31:0] d_rt_val,
    input  logic [31:0] d_imm,
    input  logic [4:0]  d_sa,
    input  logic        d_shift,
    input  logic        d_aluimm,
    input  logic [4:0]  d_rn,
    input  logic        d_wreg,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_rn,
    input  logic [31:0] ex_val,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_rn,
    input  logic [31:0] mem_val,
    output logic        e_valid,
    input  logic        e_ready,
    output logic [31:0] e_a,
    output logic [31:0] e_b,
    output logic [3:0]  e_aluc,
    output logic [4:0]  e_rn,
    output logic        e_wreg
);

    // Entry layout: {a[31:0], b[31:0], aluc[3:0], rn[4:0], wreg}
    localparam int EW = 74;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;

    logic [1:0]    state_q, state_d;
    logic [EW-1:0] out_q, out_d;
    logic [EW-1:0] in_entry;
    logic [31:0]   fwd_rs, fwd_rt;
    logic          xfer;

    // EX beats MEM; register 0 is hard-wired and never takes a bypass.
    always_comb begin
        fwd_rs = d_rs_val;
        if (d_rs != 5'd0 && ex_wreg && ex_rn == d_rs)
            fwd_rs = ex_val;
        else if (d_rs != 5'd0 && mem_wreg && mem_rn == d_rs)
            fwd_rs = mem_val;

        fwd_rt = d_rt_val;
        if (d_rt != 5'd0 && ex_wreg && ex_rn == d_rt)
            fwd_rt = ex_val;
        else if (d_rt != 5'd0 && mem_wreg && mem_rn == d_rt)
            fwd_rt = mem_val;

        in_entry = {(d_shift ? {27'b0, d_sa} : fwd_rs),
                    (d_aluimm ? d_imm : fwd_rt),
                    d_aluc, d_rn, d_wreg};
    end

    assign xfer    = d_valid & d_ready;
    assign e_valid = (state_q != ST_EMPTY);
    assign {e_a, e_b, e_aluc, e_rn, e_wreg} = out_q;

`ifdef ALU_ISSUE_SKID_EN
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [EW-1:0] skid_q, skid_d;
    logic          d_ready_q, d_ready_d;

    assign d_ready = d_ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer) begin
                        state_d = ST_ONE;
                        out_d   = in_entry;
                    end
                end
                ST_ONE: begin
                    if (e_ready && xfer) begin
                        out_d = in_entry;
                    end else if (e_ready) begin
                        state_d = ST_EMPTY;
                    end else if (xfer) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end
                end
                ST_FULL: begin
                    if (e_ready) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        d_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            d_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            d_ready_q <= d_ready_d;
        end
    end
`else
    // Without a skid the stage can only accept when the output slot drains this cycle.
    assign d_ready = ~e_valid | e_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer) begin
                        state_d = ST_ONE;
                        out_d   = in_entry;
                    end
                end
                ST_ONE: begin
                    if (xfer)
                        out_d = in_entry;
                    else if (e_ready)
                        state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end
`endif

endmodule
